// File: rtl/gcm_aes_sched.sv
// GCM AES scheduler: arbitrates tagmask (J0) and CTR keystream requests onto one
// shared AES core and returns each result to the requester that was granted.
module gcm_aes_sched #(
   parameter logic [31:0] J0_LSW   = 32'h0000_0001,
   parameter logic [31:0] CTR_INIT = 32'h0000_0002
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [95:0]  iv_in,
   input  logic         iv_we,
   input  logic         tagmask_req,
   output logic         tagmask_ack,
   output logic [127:0] mask_out,
   output logic         mask_out_valid,
   input  logic         ctr_req,
   output logic         ctr_ack,
   output logic [127:0] ks_out,
   output logic         ks_valid,
   output logic         aes_start,
   output logic [127:0] aes_block,
   input  logic         aes_ready,
   input  logic [127:0] aes_result,
   input  logic         aes_result_valid,
   output logic         busy
);

   localparam int unsigned IV_W  = 96;
   localparam int unsigned CTR_W = 32;
   localparam int unsigned BLK_W = 128;
   localparam logic        OWN_TM  = 1'b0;
   localparam logic        OWN_CTR = 1'b1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic               owner_q, owner_d;
   logic [IV_W-1:0]    iv_q, iv_d;
   logic [CTR_W-1:0]   ctr_q, ctr_d;
   logic [BLK_W-1:0]   blk_q, blk_d;
   logic [BLK_W-1:0]   mask_q, mask_d;
   logic [BLK_W-1:0]   ks_q, ks_d;
   logic               mask_v_q, mask_v_d;
   logic               ks_v_q, ks_v_d;
   logic               tm_grant, ctr_grant;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         owner_q  <= OWN_TM;
         iv_q     <= '0;
         ctr_q    <= '0;
         blk_q    <= '0;
         mask_q   <= '0;
         ks_q     <= '0;
         mask_v_q <= 1'b0;
         ks_v_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         iv_q     <= iv_d;
         ctr_q    <= ctr_d;
         blk_q    <= blk_d;
         mask_q   <= mask_d;
         ks_q     <= ks_d;
         mask_v_q <= mask_v_d;
         ks_v_q   <= ks_v_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (tagmask_req || ctr_req) state_d = ISSUE;
         ISSUE:   if (aes_ready)              state_d = WAIT;
         WAIT:    if (aes_result_valid)       state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   // Grants, datapath updates and outputs
   always_comb begin
      tm_grant  = tagmask_req && (state_q == IDLE);
      ctr_grant = ctr_req && !tagmask_req && (state_q == IDLE);
      owner_d   = owner_q;
      blk_d     = blk_q;
      iv_d      = iv_q;
      ctr_d     = ctr_q;
      mask_d    = mask_q;
      ks_d      = ks_q;
      mask_v_d  = 1'b0;
      ks_v_d    = 1'b0;

      if (tm_grant) begin
         blk_d   = {iv_q, J0_LSW};
         owner_d = OWN_TM;
      end else if (ctr_grant) begin
         blk_d   = {iv_q, ctr_q};
         ctr_d   = ctr_q + CTR_W'(1);
         owner_d = OWN_CTR;
      end

      // A fresh IV restarts the counter even if an increment happens this cycle
      if (iv_we) begin
         iv_d  = iv_in;
         ctr_d = CTR_INIT;
      end

      if ((state_q == WAIT) && aes_result_valid) begin
         if (owner_q == OWN_CTR) begin
            ks_d   = aes_result;
            ks_v_d = 1'b1;
         end else begin
            mask_d   = aes_result;
            mask_v_d = 1'b1;
         end
      end

      tagmask_ack    = tm_grant;
      ctr_ack        = ctr_grant;
      aes_start      = (state_q == ISSUE) && aes_ready;
      busy           = (state_q != IDLE);
      aes_block      = blk_q;
      mask_out       = mask_q;
      mask_out_valid = mask_v_q;
      ks_out         = ks_q;
      ks_valid       = ks_v_q;
   end

endmodule

// File: tb/tb_gcm_aes_sched.sv
// Bench for gcm_aes_sched: directed table, priority/reset sequences and random
// traffic checked against a request-level model of IV, counter and AES results.
module tb_gcm_aes_sched;

   localparam logic [31:0] J0      = 32'h0000_0001;
   localparam logic [31:0] CINIT   = 32'h0000_0002;
   localparam logic [31:0] CINIT_W = 32'hFFFF_FFFE;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [95:0]  iv_in = '0;
   logic         iv_we = 1'b0;
   logic         tagmask_req = 1'b0;
   logic         ctr_req = 1'b0;
   logic         stall = 1'b0;
   logic         aes_ready;
   logic [127:0] aes_result = '0;
   logic         aes_result_valid = 1'b0;

   logic         tagmask_ack, mask_out_valid, ctr_ack, ks_valid, aes_start, busy;
   logic [127:0] mask_out, ks_out, aes_block;
   logic         tagmask_ack_w, mask_out_valid_w, ctr_ack_w, ks_valid_w, aes_start_w, busy_w;
   logic [127:0] mask_out_w, ks_out_w, aes_block_w;

   assign aes_ready = ~stall;

   gcm_aes_sched dut (
      .clk(clk), .rst_n(rst_n), .iv_in(iv_in), .iv_we(iv_we),
      .tagmask_req(tagmask_req), .tagmask_ack(tagmask_ack),
      .mask_out(mask_out), .mask_out_valid(mask_out_valid),
      .ctr_req(ctr_req), .ctr_ack(ctr_ack), .ks_out(ks_out), .ks_valid(ks_valid),
      .aes_start(aes_start), .aes_block(aes_block), .aes_ready(aes_ready),
      .aes_result(aes_result), .aes_result_valid(aes_result_valid), .busy(busy)
   );

   gcm_aes_sched #(.CTR_INIT(CINIT_W)) dut_w (
      .clk(clk), .rst_n(rst_n), .iv_in(iv_in), .iv_we(iv_we),
      .tagmask_req(tagmask_req), .tagmask_ack(tagmask_ack_w),
      .mask_out(mask_out_w), .mask_out_valid(mask_out_valid_w),
      .ctr_req(ctr_req), .ctr_ack(ctr_ack_w), .ks_out(ks_out_w), .ks_valid(ks_valid_w),
      .aes_start(aes_start_w), .aes_block(aes_block_w), .aes_ready(aes_ready),
      .aes_result(aes_result), .aes_result_valid(aes_result_valid), .busy(busy_w)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Reference model state
   logic [95:0]  m_iv;
   logic [31:0]  m_ctr, m_ctr_w;
   int           lat_cfg = 1;
   logic         fixed_en = 1'b0;
   logic [127:0] fixed_val = '0;
   int           rv_seen = 0;

   function automatic logic [127:0] aes_f(input logic [127:0] b);
      return {b[63:0], b[127:64]} ^ 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", name, act, exp);
   endtask

   task automatic chki(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d want %0d", name, act, exp);
   endtask

   // Behavioural AES core: accepts a start, answers lat_cfg cycles later
   int           aes_cnt = 0;
   logic [127:0] aes_pend = '0;
   always begin
      @(posedge clk);
      #3;
      aes_result_valid = 1'b0;
      if (aes_cnt > 0) begin
         aes_cnt--;
         if (aes_cnt == 0) begin
            aes_result_valid = 1'b1;
            aes_result       = aes_pend;
            rv_seen++;
         end
      end
      if (aes_start) begin
         aes_cnt  = lat_cfg;
         aes_pend = fixed_en ? fixed_val : aes_f(aes_block);
      end
   end

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_mask"}, mask_out, '0);
      chk({tag, "_ks"}, ks_out, '0);
      chk({tag, "_blk"}, aes_block, '0);
      chki({tag, "_ctl"}, int'({tagmask_ack, mask_out_valid, ctr_ack, ks_valid, aes_start, busy}), 0);
      chki({tag, "_w"}, int'(|{tagmask_ack_w, mask_out_w, mask_out_valid_w, ctr_ack_w,
                               ks_out_w, ks_valid_w, aes_start_w, aes_block_w, busy_w}), 0);
   endtask

   task automatic model_reset();
      m_iv = '0; m_ctr = '0; m_ctr_w = '0;
   endtask

   task automatic iv_load(input logic [95:0] v);
      iv_we = 1'b1; iv_in = v;
      @(posedge clk); #1;
      iv_we = 1'b0;
      m_iv = v; m_ctr = CINIT; m_ctr_w = CINIT_W;
   endtask

   // One full request/result transaction; entered and left at posedge+1
   task automatic do_req(input bit tm, input bit iv_also, input logic [95:0] new_iv,
                         input int lat, input int stall_cyc, input bit use_tab,
                         input logic [31:0] tab_low, input logic [31:0] tab_low_w);
      logic [127:0] exp_blk, exp_res, got;
      logic [31:0]  exp_w;
      int nstart = 0, nv = 0, nother = 0, post = 0, unstable = 0, stall_bad = 0;
      exp_blk = tm ? {m_iv, J0} : {m_iv, m_ctr};
      exp_w   = tm ? J0 : m_ctr_w;
      exp_res = fixed_en ? fixed_val : aes_f(exp_blk);
      got     = '0;
      lat_cfg = lat;
      stall   = (stall_cyc > 0);
      if (tm) tagmask_req = 1'b1; else ctr_req = 1'b1;
      if (iv_also) begin iv_we = 1'b1; iv_in = new_iv; end
      #1;
      chki("ack", int'(tm ? tagmask_ack : ctr_ack), 1);
      @(posedge clk); #1;
      tagmask_req = 1'b0; ctr_req = 1'b0; iv_we = 1'b0;
      if (!tm) begin m_ctr = m_ctr + 32'd1; m_ctr_w = m_ctr_w + 32'd1; end
      if (iv_also) begin m_iv = new_iv; m_ctr = CINIT; m_ctr_w = CINIT_W; end
      chk("blk", aes_block, exp_blk);
      chk("blk_w_low", 128'(aes_block_w[31:0]), 128'(exp_w));
      if (use_tab) begin
         chk("tab_low", 128'(aes_block[31:0]), 128'(tab_low));
         chk("tab_low_w", 128'(aes_block_w[31:0]), 128'(tab_low_w));
      end
      if (stall_cyc > 0) begin
         for (int k = 0; k < stall_cyc; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            if (aes_start) stall_bad++;
         end
         chki("stall_no_start", stall_bad, 0);
         stall = 1'b0;
         #1;
      end
      if (aes_start) nstart++;
      for (int c = 0; c < 80 && post < 2; c++) begin
         @(posedge clk); #1;
         if (aes_start) nstart++;
         if (tm ? mask_out_valid : ks_valid) begin
            nv++;
            got = tm ? mask_out : ks_out;
         end
         if (tm ? ks_valid : mask_out_valid) nother++;
         if (nv == 0 && aes_block !== exp_blk) unstable++;
         if (nv > 0) post++;
      end
      chki("starts", nstart, 1);
      chki("valid_pulses", nv, 1);
      chki("other_valid", nother, 0);
      chki("blk_stable", unstable, 0);
      chk("result", got, exp_res);
      chki("idle_after", int'(busy), 0);
   endtask

   typedef struct {
      bit          tm;
      int          lat;
      int          stall_cyc;
      logic [31:0] low;
      logic [31:0] low_w;
   } vec_t;

   initial begin
      vec_t         tab[3];
      logic [127:0] tm_blk, c_blk;
      int           bad, got_v, late_valid, late_busy;

      tab[0] = '{tm: 1'b0, lat: 3, stall_cyc: 0, low: 32'h0000_0002, low_w: 32'hFFFF_FFFE};
      tab[1] = '{tm: 1'b0, lat: 1, stall_cyc: 0, low: 32'h0000_0003, low_w: 32'hFFFF_FFFF};
      tab[2] = '{tm: 1'b0, lat: 5, stall_cyc: 5, low: 32'h0000_0004, low_w: 32'h0000_0000};

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outs("reset");
      rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;

      // Tagmask path with a fixed AES answer
      iv_load(96'hCAFEBABE_FACEDBAD_DECAF888);
      fixed_en = 1'b1; fixed_val = {16{8'h5A}};
      do_req(1'b1, 1'b0, '0, 10, 0, 1'b1, J0, J0);
      chk("t2_block", aes_block, 128'hCAFEBABE_FACEDBAD_DECAF888_00000001);
      chk("t2_mask", mask_out, {16{8'h5A}});
      fixed_en = 1'b0;

      // Keystream sequence, wrap instance and stall
      iv_load(96'h0123_4567_89AB_CDEF_0011_2233);
      foreach (tab[i])
         do_req(tab[i].tm, 1'b0, '0, tab[i].lat, tab[i].stall_cyc, 1'b1, tab[i].low, tab[i].low_w);

      // Tagmask beats a simultaneous ctr request; ctr re-granted when mask lands
      iv_load(96'hA5A5_0000_FFFF_1234_5678_9ABC);
      lat_cfg = 4;
      tagmask_req = 1'b1; ctr_req = 1'b1;
      #1;
      chki("prio_tm_ack", int'(tagmask_ack), 1);
      chki("prio_ctr_ack", int'(ctr_ack), 0);
      tm_blk = {m_iv, J0};
      @(posedge clk); #1;
      tagmask_req = 1'b0;
      chk("prio_tm_blk", aes_block, tm_blk);
      bad = 0; got_v = 0;
      for (int c = 0; c < 40; c++) begin
         if (mask_out_valid) begin got_v = 1; break; end
         if (ctr_ack) bad++;
         @(posedge clk); #1;
      end
      chki("prio_ctr_held", bad, 0);
      chki("prio_tm_valid", got_v, 1);
      chk("prio_mask", mask_out, aes_f(tm_blk));
      #1;
      chki("prio_ctr_regrant", int'(ctr_ack), 1);
      c_blk = {m_iv, m_ctr};
      @(posedge clk); #1;
      ctr_req = 1'b0;
      m_ctr = m_ctr + 32'd1; m_ctr_w = m_ctr_w + 32'd1;
      chk("prio_ctr_low", 128'(aes_block[31:0]), 128'(32'h0000_0002));
      chk("prio_ctr_blk", aes_block, c_blk);
      got_v = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (ks_valid) begin got_v = 1; break; end
      end
      chki("prio_ks_valid", got_v, 1);
      chk("prio_ks", ks_out, aes_f(c_blk));
      @(posedge clk); #1;

      // Random traffic against the model
      for (int i = 0; i < 25; i++) begin
         int op;
         op = int'($urandom_range(0, 5));
         if (op == 0)
            iv_load({$urandom, $urandom, $urandom});
         else
            do_req(op <= 2, (op == 2) || (op == 5), {$urandom, $urandom, $urandom},
                   int'($urandom_range(1, 8)), int'($urandom_range(0, 3)), 1'b0, '0, '0);
         repeat (int'($urandom_range(0, 2))) @(posedge clk);
         #0;
      end
      @(posedge clk); #1;

      // Reset while waiting on the AES core; its late result must be dropped
      lat_cfg = 20;
      ctr_req = 1'b1;
      @(posedge clk); #1;
      ctr_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chki("t6_busy_before", int'(busy), 1);
      rv_seen = 0;
      rst_n = 1'b0;
      #1;
      chk_reset_outs("midrst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      late_valid = 0; late_busy = 0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk); #1;
         if (mask_out_valid || ks_valid) late_valid++;
         if (busy) late_busy++;
      end
      chki("t6_late_rv_seen", int'(rv_seen > 0), 1);
      chki("t6_no_valid", late_valid, 0);
      chki("t6_stay_idle", late_busy, 0);
      do_req(1'b0, 1'b0, '0, 2, 0, 1'b1, 32'h0, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
